// File: rtl/watch_calendar.sv
// Watch timekeeping core: 1 Hz prescaler plus a sec/min/12h/AM-PM/day/month/year
// cascade with leap-year handling and a validated, clamped full date/time load.
module watch_calendar #(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        load,
    input  logic [14:0] load_year,
    input  logic [6:0]  load_month,
    input  logic [6:0]  load_day,
    input  logic        load_ap,
    input  logic [6:0]  load_hour,
    input  logic [6:0]  load_min,
    output logic [14:0] year,
    output logic [6:0]  month,
    output logic [6:0]  day,
    output logic        ap,
    output logic [6:0]  hour,
    output logic [6:0]  min,
    output logic [6:0]  sec,
    output logic        is_leap_year,
    output logic        sec_pulse
);

    localparam int            PW  = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PTC = PW'(TICKS_PER_SEC - 1);

    function automatic logic leap_of(input logic [14:0] y);
        return (((y % 15'd4) == 15'd0) && ((y % 15'd100) != 15'd0)) ||
               ((y % 15'd400) == 15'd0);
    endfunction

    function automatic logic [6:0] days_in(input logic [6:0] m, input logic lp);
        case (m)
            7'd2:                       return lp ? 7'd29 : 7'd28;
            7'd4, 7'd6, 7'd9, 7'd11:    return 7'd30;
            default:                    return 7'd31;
        endcase
    endfunction

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [14:0]   year_q, year_d;
    logic [6:0]    month_q, month_d, day_q, day_d;
    logic [6:0]    hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic          ap_q, ap_d, pulse_q, pulse_d;

    logic       load_ok;
    logic [6:0] load_dim;

    assign load_ok  = load && (load_month >= 7'd1) && (load_month <= 7'd12) &&
                      (load_hour <= 7'd11) && (load_min <= 7'd59) && (load_day != 7'd0);
    assign load_dim = days_in(load_month, leap_of(load_year));

    always_comb begin
        pcnt_d  = pcnt_q;
        year_d  = year_q;
        month_d = month_q;
        day_d   = day_q;
        ap_d    = ap_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        pulse_d = 1'b0;
        if (load_ok) begin
            year_d  = load_year;
            month_d = load_month;
            day_d   = (load_day > load_dim) ? load_dim : load_day;
            ap_d    = load_ap;
            hour_d  = load_hour;
            min_d   = load_min;
            sec_d   = 7'd0;
            pcnt_d  = '0;
        end else if (run) begin
            if (pcnt_q == PTC) begin
                pcnt_d  = '0;
                pulse_d = 1'b1;
                if (sec_q == 7'd59) begin
                    sec_d = 7'd0;
                    if (min_q == 7'd59) begin
                        min_d = 7'd0;
                        if (hour_q == 7'd11) begin
                            hour_d = 7'd0;
                            ap_d   = ~ap_q;
                            // Only the PM->AM transition (midnight) starts a new day
                            if (ap_q) begin
                                if (day_q >= days_in(month_q, leap_of(year_q))) begin
                                    day_d = 7'd1;
                                    if (month_q == 7'd12) begin
                                        month_d = 7'd1;
                                        year_d  = year_q + 15'd1;
                                    end else begin
                                        month_d = month_q + 7'd1;
                                    end
                                end else begin
                                    day_d = day_q + 7'd1;
                                end
                            end
                        end else begin
                            hour_d = hour_q + 7'd1;
                        end
                    end else begin
                        min_d = min_q + 7'd1;
                    end
                end else begin
                    sec_d = sec_q + 7'd1;
                end
            end else begin
                pcnt_d = pcnt_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_q  <= '0;
            year_q  <= 15'd2019;
            month_q <= 7'd1;
            day_q   <= 7'd1;
            ap_q    <= 1'b0;
            hour_q  <= 7'd0;
            min_q   <= 7'd0;
            sec_q   <= 7'd0;
            pulse_q <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            year_q  <= year_d;
            month_q <= month_d;
            day_q   <= day_d;
            ap_q    <= ap_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            pulse_q <= pulse_d;
        end
    end

    assign year         = year_q;
    assign month        = month_q;
    assign day          = day_q;
    assign ap           = ap_q;
    assign hour         = hour_q;
    assign min          = min_q;
    assign sec          = sec_q;
    assign sec_pulse    = pulse_q;
    assign is_leap_year = leap_of(year_q);

endmodule
